bus_slave_regs: RTL

Bus responder (slave end) of the shared system-bus protocol driven by the CPU-side bus master interface. It accepts a single-cycle address strobe from the granted master, inserts a programmable number of wait states, and completes the access with a one-cycle active-low ready pulse. Writes land in a small 32-bit register bank; reads return register contents. It sits on one slave slot behind the bus address decoder and arbiter. `rd_data` is zero whenever idle, so it can be OR-combined onto the shared read bus.

---
 rtl/bus_slave_regs.sv | 110 +++++++++++
 1 files changed

// File: rtl/bus_slave_regs.sv
// bus_slave_regs: system-bus slave with programmable wait states, a one-cycle
// active-low ready pulse, seven R/W registers and a read-only ID register.
module bus_slave_regs #(
  parameter int unsigned WAIT_CYCLES = 1,
  parameter logic [31:0] ID_VALUE    = 32'h0000_A5A5
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        cs_,
  input  logic        as_,
  input  logic        rw,
  input  logic [2:0]  addr,
  input  logic [31:0] wr_data,
  output logic [31:0] rd_data,
  output logic        rdy_
);

  localparam logic [1:0] ST_IDLE  = 2'd0;
  localparam logic [1:0] ST_WAIT  = 2'd1;
  localparam logic [1:0] ST_READY = 2'd2;

  localparam logic [3:0] WAIT_LOAD = (WAIT_CYCLES == 0) ? 4'd0 : 4'(WAIT_CYCLES - 1);

  logic [1:0]  state;
  logic [3:0]  wait_cnt;
  logic        lat_rw;
  logic [2:0]  lat_addr;
  logic [31:0] lat_data;
  logic [31:0] regs [0:6];

  logic        accept;
  logic        complete;
  logic        cmp_rw;
  logic [2:0]  cmp_addr;
  logic [31:0] cmp_data;
  logic [31:0] read_val;

  // With zero wait states the access completes on the accepting edge, so the
  // live bus inputs stand in for the not-yet-latched copies.
  always_comb begin
    accept   = (state == ST_IDLE) && !cs_ && !as_;
    complete = 1'b0;
    cmp_rw   = lat_rw;
    cmp_addr = lat_addr;
    cmp_data = lat_data;
    if (accept && (WAIT_CYCLES == 0)) begin
      complete = 1'b1;
      cmp_rw   = rw;
      cmp_addr = addr;
      cmp_data = wr_data;
    end else if ((state == ST_WAIT) && (wait_cnt == 4'd0)) begin
      complete = 1'b1;
    end
  end

  always_comb begin
    read_val = ID_VALUE;
    for (int i = 0; i < 7; i++) begin
      if (cmp_addr == 3'(i)) read_val = regs[i];
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state    <= ST_IDLE;
      wait_cnt <= 4'd0;
      lat_rw   <= 1'b0;
      lat_addr <= 3'd0;
      lat_data <= 32'd0;
      rdy_     <= 1'b1;
      rd_data  <= 32'd0;
    end else begin
      rdy_    <= 1'b1;
      rd_data <= 32'd0;
      case (state)
        ST_IDLE: begin
          if (accept) begin
            lat_rw   <= rw;
            lat_addr <= addr;
            lat_data <= wr_data;
            wait_cnt <= WAIT_LOAD;
            state    <= (WAIT_CYCLES == 0) ? ST_READY : ST_WAIT;
          end
        end
        ST_WAIT: begin
          if (wait_cnt == 4'd0) state <= ST_READY;
          else wait_cnt <= wait_cnt - 4'd1;
        end
        ST_READY: state <= ST_IDLE;
        default:  state <= ST_IDLE;
      endcase
      if (complete) begin
        rdy_ <= 1'b0;
        if (cmp_rw) rd_data <= read_val;
      end
    end
  end

  // Reg 7 has no storage; writes to it are acknowledged but dropped.
  always_ff @(posedge clk) begin
    if (reset) begin
      for (int i = 0; i < 7; i++) regs[i] <= 32'd0;
    end else if (complete && !cmp_rw) begin
      for (int i = 0; i < 7; i++) begin
        if (cmp_addr == 3'(i)) regs[i] <= cmp_data;
      end
    end
  end

endmodule
